muldiv_iter: RTL

- Parametrised iterative multiply/divide unit; successor to the single-width fixed-latency multiplier/divider pair in the execute stage.
- Executes all eight RV M-extension ops on a shared WIDTH-bit datapath.
- Configurable bits retired per cycle.
- valid/ready request and response handshakes, kill, early-out for div-by-zero and signed overflow.
- Sits beside the ALU in the execute stage; the control unit stalls on `busy_o`.

---
 rtl/muldiv_pkg.sv | 39 +++
 rtl/muldiv_step.sv | 42 ++++
 rtl/muldiv_iter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and op-decoding helpers for the iterative RV M-extension unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } md_state_e;

  // True for every op that runs the divider (quotient or remainder).
  function automatic logic is_div(md_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_rem(md_op_e op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  function automatic logic is_signed_a(md_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(md_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One CALC iteration: BITS_PER_CYCLE shift-add (multiply) or restoring
// subtract-compare (divide) steps on the {hi, lo} accumulator.
module muldiv_step #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  input  logic               div_mode_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [2*WIDTH-1:0] cur;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;

  always_comb begin
    cur    = acc_i;
    sum    = '0;
    rem_sh = '0;
    diff   = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (div_mode_i) begin
        // hi = partial remainder, lo = dividend shifting out / quotient shifting in
        rem_sh = {cur[2*WIDTH-1:WIDTH], cur[WIDTH-1]};
        diff   = rem_sh - {1'b0, opnd_i};
        if (!diff[WIDTH]) begin
          cur = {diff[WIDTH-1:0], cur[WIDTH-2:0], 1'b1};
        end else begin
          cur = {rem_sh[WIDTH-1:0], cur[WIDTH-2:0], 1'b0};
        end
      end else begin
        // hi = partial product, lo = multiplier bits consumed from the LSB
        sum = {1'b0, cur[2*WIDTH-1:WIDTH]} + (cur[0] ? {1'b0, opnd_i} : '0);
        cur = {sum, cur[WIDTH-1:1]};
      end
    end
    acc_o = cur;
  end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit for all eight RV M-extension ops, operating
// on operand magnitudes with sign fix-up applied in a single FIX cycle.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             kill_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o
);

  localparam int unsigned N_ITER = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CW     = $clog2(N_ITER + 1);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  md_state_e          state_q, state_d;
  md_op_e             op_q;
  logic               sa_q, sb_q, fast_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   result_q;

  md_op_e             op_in;
  logic               sa_in, sb_in, fast_in, accept;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] step_acc;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, fix_res;

  assign req_ready_o  = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign resp_valid_o = (state_q == DONE);
  assign result_o     = result_q;

  always_comb begin
    op_in   = md_op_e'(op_i);
    sa_in   = is_signed_a(op_in) & a_i[WIDTH-1];
    sb_in   = is_signed_b(op_in) & b_i[WIDTH-1];
    a_mag   = sa_in ? -a_i : a_i;
    b_mag   = sb_in ? -b_i : b_i;
    fast_in = is_div(op_in) &
              ((b_i == '0) | (is_signed_a(op_in) & (a_i == MIN) & (b_i == '1)));
    accept  = req_valid_i & req_ready_o & ~kill_i;
  end

  muldiv_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .acc_i      (acc_q),
    .opnd_i     (opnd_q),
    .div_mode_i (is_div(op_q)),
    .acc_o      (step_acc)
  );

  // Fast path never iterates, so acc_q lo still holds |a| for the div-by-zero remainder.
  always_comb begin
    prod    = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo     = acc_q[WIDTH-1:0];
    rem     = acc_q[2*WIDTH-1:WIDTH];
    fix_res = '0;
    if (!is_div(op_q)) begin
      fix_res = (op_q == OP_MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    end else if (is_rem(op_q)) begin
      if (fast_q) fix_res = (opnd_q == '0) ? (sa_q ? -quo : quo) : '0;
      else        fix_res = sa_q ? -rem : rem;
    end else begin
      if (fast_q) fix_res = (opnd_q == '0) ? '1 : MIN;
      else        fix_res = (sa_q ^ sb_q) ? -quo : quo;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = fast_in ? FIX : CALC;
      CALC: begin
        if (kill_i)                 state_d = IDLE;
        else if (cnt_q == CW'(1))   state_d = FIX;
      end
      FIX:  state_d = kill_i ? IDLE : DONE;
      DONE: if (kill_i || resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q     <= OP_MUL;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      fast_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          op_q   <= op_in;
          sa_q   <= sa_in;
          sb_q   <= sb_in;
          fast_q <= fast_in;
          cnt_q  <= CW'(N_ITER);
          acc_q  <= is_div(op_in) ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
          opnd_q <= is_div(op_in) ? b_mag : a_mag;
        end
        CALC: if (!kill_i) begin
          acc_q <= step_acc;
          cnt_q <= cnt_q - CW'(1);
        end
        FIX: if (!kill_i) result_q <= fix_res;
        default: ;
      endcase
    end
  end

endmodule
